// File: rtl/wb_master_bus_fsm.sv
// Wishbone B4 classic single-transfer initiator.
// One core request becomes one Wishbone cycle, with a bus timeout.
module wb_master_bus_fsm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = DATA_W / 8,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [SEL_W-1:0]  req_sel,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_t              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [TMO_W-1:0]    cnt_q, cnt_d;

    // State and bus/response registers; reset drops the cycle at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept in IDLE, wait for err/ack/timeout in BUS
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    adr_d   = req_addr;
                    dat_d   = req_wdata;
                    sel_d   = req_sel;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_err_i) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else if (wb_ack_i) begin
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : wb_dat_i;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;

endmodule

// File: tb/tb_wb_master_bus_fsm.sv
// Directed bench for wb_master_bus_fsm with a response scoreboard.
// Expected responses are queued at request time and popped on rsp_valid.
module tb_wb_master_bus_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];

    wb_master_bus_fsm #(
        .ADDR_W(32), .DATA_W(32), .SEL_W(4), .TMO_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_sel(req_sel), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response must match the oldest queued one
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    // One transfer; slave terminates after 'waits' wait cycles
    task automatic xfer(input string tag, input logic we,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [3:0] sel, input int waits,
                        input logic [31:0] din, input logic ack,
                        input logic err);
        rsp_t e;
        wait_ready();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_sel   = sel;
        e.err   = err || !ack;
        e.rdata = (e.err || we) ? 32'h0 : din;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hBAD0BAD0;
        req_wdata = 32'hFFFF0000;
        req_sel   = ~sel;
        for (int i = 0; i <= waits; i++) begin
            wb_ack_i = (i == waits) && ack;
            wb_err_i = (i == waits) && err;
            wb_dat_i = din;
            @(negedge clk);
            chk({tag, "_cyc"}, 32'(wb_cyc_o & wb_stb_o), 32'd1);
            chk({tag, "_adr"}, wb_adr_o, addr);
            chk({tag, "_we"}, 32'(wb_we_o), 32'(we));
            chk({tag, "_dat"}, wb_dat_o, wdata);
            chk({tag, "_sel"}, 32'(wb_sel_o), 32'(sel));
            chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        @(negedge clk);
        chk({tag, "_cyc_off"}, 32'(wb_cyc_o | wb_stb_o), 32'd0);
        chk({tag, "_we_off"}, 32'(wb_we_o), 32'd0);
        chk({tag, "_rv"}, 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk({tag, "_rv_off"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(req_ready), 32'd1);
    endtask

    logic cyc_s[6];
    logic rv_s[6];
    logic [5:0] cyc_v, rv_v;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_sel   = 4'h0;
        wb_dat_i  = 32'h0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        #12;
        chk("rst_cyc", 32'(wb_cyc_o | wb_stb_o | wb_we_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o | rsp_rdata, 32'h0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_rsp", 32'(rsp_valid | rsp_err), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Ack/err in IDLE must be ignored
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ack_ignored", 32'(rsp_valid | wb_cyc_o), 32'd0);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;

        xfer("t1_rd", 1'b0, 32'h100, 32'h0, 4'hF, 0,
             32'hDEADBEEF, 1'b1, 1'b0);
        xfer("t2_wr", 1'b1, 32'h200, 32'h12345678, 4'b0011, 3,
             32'hCAFEF00D, 1'b1, 1'b0);
        xfer("t3_both", 1'b0, 32'h300, 32'h0, 4'hF, 0,
             32'h55AA55AA, 1'b1, 1'b1);
        xfer("t4_tmo", 1'b0, 32'h400, 32'h0, 4'hF, 15,
             32'h11111111, 1'b0, 1'b0);

        // Back-to-back reads with req_valid held and ack held
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h500;
        req_sel   = 4'hF;
        wb_ack_i  = 1'b1;
        wb_dat_i  = 32'h0BADCAFE;
        sb.push_back('{32'h0BADCAFE, 1'b0});
        sb.push_back('{32'h0BADCAFE, 1'b0});
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            cyc_s[k] = wb_cyc_o;
            rv_s[k]  = rsp_valid;
            if (k == 4) req_valid = 1'b0;
        end
        wb_ack_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc_v[k] = cyc_s[k];
            rv_v[k]  = rv_s[k];
        end
        chk("t5_cyc_pattern", 32'(cyc_v), 32'b001001);
        chk("t5_rv_pattern", 32'(rv_v), 32'b010010);

        // Reset during a BUS wait: no response may follow
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h600;
        req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_in_bus", 32'(wb_cyc_o), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_cyc_drop", 32'(wb_cyc_o | wb_stb_o), 32'd0);
        chk("t6_adr_clr", wb_adr_o, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        xfer("t6_after", 1'b0, 32'h700, 32'h0, 4'hF, 1,
             32'h76543210, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
